// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into 32-bit words
// and writes them to instruction memory from word 0, holding the core.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              hold,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] MAX_LEN =
    (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE_LEN =
    (ADDR_W+1)'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_byte_idx;
  logic [1:0]          w_byte_idx_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   r_word;
  logic [DATA_W-1:0]   w_word_nxt;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     w_len_nxt;

  logic                w_accept;
  logic                w_last;
  logic [ADDR_W:0]     w_len_clamp;

  // abort outranks byte acceptance
  assign w_accept = (r_state == S_RECV) &
                    byte_valid & ~abort;

  assign w_last = ({1'b0, r_addr} == (r_len - ONE_LEN));

  assign w_len_clamp = (load_len > MAX_LEN) ?
                       MAX_LEN : load_len;

  always_comb begin
    w_state_nxt    = r_state;
    w_byte_idx_nxt = r_byte_idx;
    w_addr_nxt     = r_addr;
    w_word_nxt     = r_word;
    w_len_nxt      = r_len;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          if (load_len != '0) begin
            w_state_nxt    = S_RECV;
            w_len_nxt      = w_len_clamp;
            w_addr_nxt     = '0;
            w_byte_idx_nxt = '0;
            w_word_nxt     = '0;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RECV: begin
        if (abort) begin
          w_state_nxt    = S_IDLE;
          w_byte_idx_nxt = '0;
          w_word_nxt     = '0;
        end else if (w_accept) begin
          w_word_nxt[8*r_byte_idx +: 8] = byte_data;
          w_byte_idx_nxt = r_byte_idx + 2'd1;
          if (r_byte_idx == 2'd3) begin
            w_state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (abort) begin
          w_state_nxt    = S_IDLE;
          w_byte_idx_nxt = '0;
          w_word_nxt     = '0;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_state_nxt = S_RECV;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_byte_idx <= '0;
      r_addr     <= '0;
      r_word     <= '0;
      r_len      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_addr     <= w_addr_nxt;
      r_word     <= w_word_nxt;
      r_len      <= w_len_nxt;
    end
  end

  assign byte_ready = (r_state == S_RECV);
  assign wr_en      = (r_state == S_WRITE) & ~abort;
  assign wr_addr    = r_addr;
  assign wr_data    = r_word;
  assign busy       = (r_state != S_IDLE);
  assign hold       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed load sequences with a write scoreboard
// checked on the falling clock edge.
module tb_imem_loader;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   load_len;
  logic          abort;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          hold;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .load_len   (load_len),
    .abort      (abort),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .hold       (hold),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t q[$];
  int  total = 0;
  int  bad = 0;
  int  wr_cnt = 0;
  int  done_cnt = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (done === 1'b1) done_cnt++;
    if (wr_en === 1'b1) begin
      wr_cnt++;
      check("wr_byte_ready", 32'(byte_ready), 32'd0);
      check("wr_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", wr_data, e.d);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int a, input logic [31:0] d);
    wr_t e;
    e.a = AW'(a);
    e.d = d;
    q.push_back(e);
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    bit ok;
    int n;
    byte_valid = 1'b0;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    do begin
      ok = byte_ready;
      tick();
      n++;
    end while (!ok && n < 50);
    if (!ok) check("byte_timeout", 32'(ok), 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input int gap);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
  endtask

  task automatic start_load(input logic [AW:0] n);
    start    = 1'b1;
    load_len = n;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int w0;
    int d0;
    logic [31:0] w;
    logic [7:0]  b;
    rst_n      = 1'b0;
    start      = 1'b0;
    load_len   = '0;
    abort      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    tick();

    // single word, back-to-back bytes
    push(0, 32'h0010_0513);
    d0 = done_cnt;
    start_load(7'd1);
    check("single_hold", 32'(hold), 32'd1);
    send_word(32'h0010_0513, 0);
    check("single_wr_en", 32'(wr_en), 32'd1);
    check("single_addr", 32'(wr_addr), 32'd0);
    check("single_data", wr_data, 32'h0010_0513);
    tick();
    check("single_done", 32'(done), 32'd1);
    check("single_done_wr", 32'(wr_en), 32'd0);
    check("single_done_hold", 32'(hold), 32'd1);
    tick();
    check("single_idle_hold", 32'(hold), 32'd0);
    check("single_idle_busy", 32'(busy), 32'd0);
    check("single_idle_done", 32'(done), 32'd0);
    check("single_done_cnt", 32'(done_cnt - d0), 32'd1);

    // stalled stream
    push(0, 32'hDEAD_BEEF);
    push(1, 32'h1234_5678);
    w0 = wr_cnt;
    d0 = done_cnt;
    start_load(7'd2);
    send_word(32'hDEAD_BEEF, 1);
    send_word(32'h1234_5678, 1);
    tick();
    wait_idle();
    check("stall_writes", 32'(wr_cnt - w0), 32'd2);
    check("stall_dones", 32'(done_cnt - d0), 32'd1);

    // zero length
    w0 = wr_cnt;
    start_load(7'd0);
    check("zero_done", 32'(done), 32'd1);
    tick();
    check("zero_idle", 32'(busy), 32'd0);
    check("zero_writes", 32'(wr_cnt - w0), 32'd0);

    // clamp 100 -> 64
    w0 = wr_cnt;
    d0 = done_cnt;
    start_load(7'd100);
    for (int i = 0; i < 64; i++) begin
      b = 8'(i);
      w = {b ^ 8'hA5, b, 8'h3C, ~b};
      push(i, w);
      send_word(w, 0);
    end
    check("clamp_last_en", 32'(wr_en), 32'd1);
    check("clamp_last_addr", 32'(wr_addr), 32'd63);
    tick();
    check("clamp_done", 32'(done), 32'd1);
    tick();
    check("clamp_writes", 32'(wr_cnt - w0), 32'd64);
    check("clamp_dones", 32'(done_cnt - d0), 32'd1);
    check("clamp_idle", 32'(busy), 32'd0);

    // abort in the write of word 2 of 3
    w0 = wr_cnt;
    d0 = done_cnt;
    push(0, 32'hA0A1_A2A3);
    start_load(7'd3);
    send_word(32'hA0A1_A2A3, 0);
    send_word(32'hB0B1_B2B3, 0);
    check("abort_addr", 32'(wr_addr), 32'd1);
    abort = 1'b1;
    #1;
    check("abort_wr_en", 32'(wr_en), 32'd0);
    tick();
    abort = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    tick();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_writes", 32'(wr_cnt - w0), 32'd1);
    push(0, 32'hC0C1_C2C3);
    start_load(7'd1);
    send_word(32'hC0C1_C2C3, 0);
    check("reload_addr", 32'(wr_addr), 32'd0);
    tick();
    tick();

    // start ignored while busy
    w0 = wr_cnt;
    d0 = done_cnt;
    push(0, 32'h1111_2222);
    push(1, 32'h3333_4444);
    start_load(7'd2);
    send_word(32'h1111_2222, 0);
    start    = 1'b1;
    load_len = 7'd5;
    tick();
    start    = 1'b0;
    send_word(32'h3333_4444, 0);
    tick();
    wait_idle();
    check("busy_start_writes", 32'(wr_cnt - w0), 32'd2);
    check("busy_start_dones", 32'(done_cnt - d0), 32'd1);

    // start with abort in IDLE, then reset mid-RECV
    w0 = wr_cnt;
    abort = 1'b1;
    start_load(7'd2);
    abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd1);
    check("start_abort_ready", 32'(byte_ready), 32'd1);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    rst_n = 1'b0;
    tick();
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_hold", 32'(hold), 32'd0);
    check("mid_rst_ready", 32'(byte_ready), 32'd0);
    check("mid_rst_data", wr_data, 32'd0);
    check("mid_rst_addr", 32'(wr_addr), 32'd0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_writes", 32'(wr_cnt - w0), 32'd0);
    check("queue_empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction ROM: assembles a little-endian byte stream (e.g. from a UART receiver or debug port) into 32-bit instruction words.
- Writes each word sequentially into the instruction memory's write port, starting at word address 0.
- Asserts a hold to the core while loading, so fetch is flushed and no partially loaded program executes.

Parameters:
- ADDR_W, 6, instruction-memory word-address width (64 words).
- DATA_W, 32, instruction word width; fixed at 4 bytes.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- load_len  input  ADDR_W+1  number of words to load; latched on accepted start.
- abort  input  1  cancels a load in progress.
- byte_valid  input  1  byte_data valid this cycle.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction-memory write strobe.
- wr_addr  output  ADDR_W  word address for the write.
- wr_data  output  DATA_W  assembled word.
- hold  output  1  high while a load is in progress; drives the fetch flush/stall.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the last word has been written.

Behaviour:
- Reset (rst_n=0 at an edge, any state, including mid-load):
  - state=IDLE.
  - byte_idx=0, addr=0, assembly register=0, latched length=0.
  - All outputs 0.
  - A partially assembled word is discarded; already written words are not undone.
- States: IDLE, RECV, WRITE, DONE. byte_ready, wr_en, hold, busy and done decode from state; wr_en is additionally gated by abort.
- IDLE:
  - start=1 with load_len>0: latch len=min(load_len, 2^ADDR_W); addr=0; byte_idx=0; next state RECV.
  - start=1 with load_len=0: next state DONE; no writes.
  - start in any other state is ignored.
- RECV:
  - byte_ready=1, hold=1.
  - A byte is accepted when byte_valid & byte_ready.
  - Accepted byte goes to lane byte_idx: byte 0 -> [7:0], byte 3 -> [31:24]. byte_idx then increments.
  - Acceptance of the byte at byte_idx=3: byte_idx wraps to 0, next state WRITE.
  - byte_valid=0: the loader waits indefinitely; no timeout.
- WRITE (exactly one cycle):
  - byte_ready=0; wr_en=1; wr_addr=addr; wr_data=assembled word.
  - addr==len-1: next state DONE.
  - Otherwise: addr increments, next state RECV.
- DONE (one cycle): done=1, hold=1, busy=1; next state IDLE.
- abort=1 in RECV or WRITE:
  - Next state IDLE; partial word discarded.
  - wr_en forced 0 in that cycle; done is not pulsed.
  - abort in IDLE or DONE has no effect; DONE still pulses.
- Latency and throughput:
  - wr_en rises in the cycle after the 4th byte of a word is accepted.
  - With byte_valid held high: 5 cycles per word; done arrives 1 cycle after the last write.
- Width rules:
  - addr never exceeds len-1, so no wrap past 2^ADDR_W-1.
  - load_len values above 2^ADDR_W are clamped to 2^ADDR_W.
- Simultaneous events:
  - rst_n beats abort beats byte acceptance.
  - start together with abort in IDLE: start is honoured.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-RECV with 2 bytes accepted -> next cycle state IDLE; all outputs 0; no wr_en.
- Single word: start, load_len=1, then bytes 0x13,0x05,0x10,0x00 back-to-back -> one wr_en with wr_addr=0, wr_data=0x00100513; done pulses 1 cycle later; hold falls with IDLE.
- Stalled stream: load_len=2, byte_valid toggling every other cycle -> exactly 2 writes to addr 0 and 1, correct words, done once, byte_ready low during WRITE.
- Zero and clamp: load_len=0 -> done next cycle, no writes. load_len=100 (ADDR_W=6) -> exactly 64 writes at addr 0..63, last at 63.
- Abort: abort in the WRITE cycle of word 2 of 3 -> wr_en=0 that cycle; IDLE next; no done. A new start then reloads from addr 0.
- Start ignored while busy: pulse start with load_len=5 during a 2-word load -> still exactly 2 writes and one done.
